// File: rtl/insn_queue_param.sv
// insn_queue_param: circular fetch-to-dispatch instruction buffer with branch-tag squash and resolve.
// Latency: an entry accepted in cycle N appears on the dispatch lanes in cycle N+1.
// Backpressure: enq_count accepts only what fits in free_entries; dispatch consumes via deq_count (clamped to out_valid).
// Optional build macro INSNQ_PERF_EN adds the perf_full_cycles / perf_squashed counters.
module insn_queue_param #(
    parameter int  DEPTH     = 8,
    parameter int  IN_WIDTH  = 4,
    parameter int  OUT_WIDTH = 3,
    parameter int  BMASK_W   = 4,
    parameter int  XLEN      = 32,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1),
    localparam int EW        = $clog2(IN_WIDTH + 1),
    localparam int DW        = $clog2(OUT_WIDTH + 1)
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           flush,
    input  logic                           br_resolve_valid,
    input  logic                           br_correct,
    input  logic [BMASK_W-1:0]             br_tag,
    input  logic [IN_WIDTH-1:0]            in_valid,
    input  logic [IN_WIDTH*32-1:0]         in_inst,
    input  logic [IN_WIDTH*XLEN-1:0]       in_pc,
    input  logic [IN_WIDTH*XLEN-1:0]       in_npc,
    input  logic [IN_WIDTH*XLEN-1:0]       in_pred_pc,
    input  logic [IN_WIDTH*BMASK_W-1:0]    in_branch_mask,
    input  logic [IN_WIDTH*BMASK_W-1:0]    in_branch_stack,
    output logic [EW-1:0]                  enq_count,
    output logic [CW-1:0]                  free_entries,
    output logic [CW-1:0]                  occupancy,
    output logic [OUT_WIDTH-1:0]           out_valid,
    output logic [OUT_WIDTH*32-1:0]        out_inst,
    output logic [OUT_WIDTH*XLEN-1:0]      out_pc,
    output logic [OUT_WIDTH*XLEN-1:0]      out_npc,
    output logic [OUT_WIDTH*XLEN-1:0]      out_pred_pc,
    output logic [OUT_WIDTH*BMASK_W-1:0]   out_branch_mask,
    output logic [OUT_WIDTH*BMASK_W-1:0]   out_branch_stack,
`ifdef INSNQ_PERF_EN
    output logic [31:0]                    perf_full_cycles,
    output logic [31:0]                    perf_squashed,
`endif
    input  logic [DW-1:0]                  deq_count
);

    logic [31:0]      inst_q  [DEPTH];
    logic [31:0]      inst_d  [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  pc_d    [DEPTH];
    logic [XLEN-1:0]  npc_q   [DEPTH];
    logic [XLEN-1:0]  npc_d   [DEPTH];
    logic [XLEN-1:0]  pred_q  [DEPTH];
    logic [XLEN-1:0]  pred_d  [DEPTH];
    logic [BMASK_W-1:0] mask_q  [DEPTH];
    logic [BMASK_W-1:0] mask_d  [DEPTH];
    logic [BMASK_W-1:0] stack_q [DEPTH];
    logic [BMASK_W-1:0] stack_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    occ_q, occ_d;

    logic             mispredict, resolve_ok;
    logic [BMASK_W-1:0] clr_mask;
    logic [CW-1:0]    free;
    logic [EW-1:0]    in_cnt, enq;
    logic             in_stop;
    logic [DW-1:0]    vld_cnt, deq_cl;
    logic             found;
    logic [CW-1:0]    match_off;

    assign mispredict   = br_resolve_valid & ~br_correct;
    assign resolve_ok   = br_resolve_valid & br_correct;
    assign clr_mask     = resolve_ok ? br_tag : '0;
    assign free         = CW'(DEPTH) - occ_q;
    assign free_entries = free;
    assign occupancy    = occ_q;
    assign enq_count    = enq;

    // Accept the contiguous valid prefix, limited by space freed before this cycle.
    always_comb begin
        in_cnt  = '0;
        in_stop = 1'b0;
        for (int j = 0; j < IN_WIDTH; j++) begin
            if (!in_stop && in_valid[j]) in_cnt = in_cnt + EW'(1);
            else                         in_stop = 1'b1;
        end
        enq = (CW'(in_cnt) > free) ? EW'(free) : in_cnt;
        if (!reset_n || flush || mispredict) enq = '0;
    end

    // Dispatch view: oldest entries, a branch only in lane 0 and ending the group, squashed lanes hidden.
    always_comb begin : dispatch_view
        logic [PW-1:0] slot;
        logic          lane_ok;
        logic          chain;
        slot             = '0;
        lane_ok          = 1'b0;
        chain            = 1'b1;
        vld_cnt          = '0;
        out_valid        = '0;
        out_inst         = '0;
        out_pc           = '0;
        out_npc          = '0;
        out_pred_pc      = '0;
        out_branch_mask  = '0;
        out_branch_stack = '0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            slot    = head_q + PW'(k);
            lane_ok = (CW'(k) < occ_q) && vld_q[slot] && !flush;
            if (mispredict && |(mask_q[slot] & br_tag)) lane_ok = 1'b0;
            if (k != 0 && |stack_q[slot])               lane_ok = 1'b0;
            chain        = chain && lane_ok;
            out_valid[k] = chain;
            if (chain) begin
                out_inst[k*32 +: 32]                   = inst_q[slot];
                out_pc[k*XLEN +: XLEN]                 = pc_q[slot];
                out_npc[k*XLEN +: XLEN]                = npc_q[slot];
                out_pred_pc[k*XLEN +: XLEN]            = pred_q[slot];
                out_branch_mask[k*BMASK_W +: BMASK_W]  = mask_q[slot] & ~clr_mask;
                out_branch_stack[k*BMASK_W +: BMASK_W] = stack_q[slot];
                vld_cnt                                = vld_cnt + DW'(1);
            end
            if (|stack_q[slot]) chain = 1'b0;
        end
        deq_cl = (deq_count > vld_cnt) ? vld_cnt : deq_count;
    end

    // Oldest stored entry that depends on the resolving branch: the squash point.
    always_comb begin : squash_search
        logic [PW-1:0] slot;
        slot      = '0;
        found     = 1'b0;
        match_off = occ_q;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if (!found && (CW'(i) < occ_q) && |(mask_q[slot] & br_tag)) begin
                found     = 1'b1;
                match_off = CW'(i);
            end
        end
    end

    // Next state: flush beats mispredict beats normal enqueue; dequeue applies except under flush.
    always_comb begin : next_state
        logic [PW-1:0] slot;
        slot    = '0;
        inst_d  = inst_q;
        pc_d    = pc_q;
        npc_d   = npc_q;
        pred_d  = pred_q;
        mask_d  = mask_q;
        stack_d = stack_q;
        vld_d   = vld_q;
        head_d  = head_q + PW'(deq_cl);
        tail_d  = tail_q;
        occ_d   = occ_q;
        if (resolve_ok) begin
            for (int i = 0; i < DEPTH; i++) mask_d[i] = mask_q[i] & ~br_tag;
        end
        for (int k = 0; k < OUT_WIDTH; k++) begin
            slot = head_q + PW'(k);
            if (DW'(k) < deq_cl) vld_d[slot] = 1'b0;
        end
        if (mispredict && found) begin
            tail_d = head_q + PW'(match_off);
            occ_d  = match_off - CW'(deq_cl);
            for (int i = 0; i < DEPTH; i++) begin
                slot = head_q + PW'(i);
                if ((CW'(i) >= match_off) && (CW'(i) < occ_q)) vld_d[slot] = 1'b0;
            end
        end else begin
            for (int j = 0; j < IN_WIDTH; j++) begin
                slot = tail_q + PW'(j);
                if (EW'(j) < enq) begin
                    inst_d[slot]  = in_inst[j*32 +: 32];
                    pc_d[slot]    = in_pc[j*XLEN +: XLEN];
                    npc_d[slot]   = in_npc[j*XLEN +: XLEN];
                    pred_d[slot]  = in_pred_pc[j*XLEN +: XLEN];
                    mask_d[slot]  = in_branch_mask[j*BMASK_W +: BMASK_W] & ~clr_mask;
                    stack_d[slot] = in_branch_stack[j*BMASK_W +: BMASK_W];
                    vld_d[slot]   = 1'b1;
                end
            end
            tail_d = tail_q + PW'(enq);
            occ_d  = occ_q + CW'(enq) - CW'(deq_cl);
        end
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            vld_d  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_d[i]  = '0;
                pc_d[i]    = '0;
                npc_d[i]   = '0;
                pred_d[i]  = '0;
                mask_d[i]  = '0;
                stack_d[i] = '0;
            end
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            vld_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i]  <= '0;
                pc_q[i]    <= '0;
                npc_q[i]   <= '0;
                pred_q[i]  <= '0;
                mask_q[i]  <= '0;
                stack_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            vld_q   <= vld_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            pred_q  <= pred_d;
            mask_q  <= mask_d;
            stack_q <= stack_d;
        end
    end

`ifdef INSNQ_PERF_EN
    logic [31:0] pf_full_q, pf_full_d, pf_sq_q, pf_sq_d;
    logic [CW-1:0] sq_amt;
    logic [32:0]   sq_sum;

    // Saturating counters: fetch stalled on a full queue, and entries thrown away by squash/flush.
    always_comb begin
        pf_full_d = pf_full_q;
        if ((occ_q == CW'(DEPTH)) && in_valid[0] && (pf_full_q != '1)) pf_full_d = pf_full_q + 32'd1;
        sq_amt = '0;
        if (flush)                    sq_amt = occ_q;
        else if (mispredict && found) sq_amt = occ_q - match_off;
        sq_sum  = {1'b0, pf_sq_q} + 33'(sq_amt);
        pf_sq_d = sq_sum[32] ? '1 : sq_sum[31:0];
    end

    // Perf counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pf_full_q <= '0;
            pf_sq_q   <= '0;
        end else begin
            pf_full_q <= pf_full_d;
            pf_sq_q   <= pf_sq_d;
        end
    end

    assign perf_full_cycles = pf_full_q;
    assign perf_squashed    = pf_sq_q;
`endif

endmodule

// File: tb/tb_insn_queue_param.sv
// Bench for insn_queue_param: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_insn_queue_param;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] pred;
        logic [3:0]  mask;
        logic [3:0]  stack;
    } ent_t;

    logic         clock, reset_n, flush, br_resolve_valid, br_correct;
    logic [3:0]   br_tag;
    logic [3:0]   in_valid;
    logic [127:0] in_inst, in_pc, in_npc, in_pred_pc;
    logic [15:0]  in_branch_mask, in_branch_stack;
    logic [2:0]   enq_count;
    logic [3:0]   free_entries, occupancy;
    logic [2:0]   out_valid;
    logic [95:0]  out_inst, out_pc, out_npc, out_pred_pc;
    logic [11:0]  out_branch_mask, out_branch_stack;
    logic [1:0]   deq_count;

    int errs   = 0;
    int checks = 0;

    insn_queue_param dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .br_resolve_valid(br_resolve_valid), .br_correct(br_correct), .br_tag(br_tag),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_npc(in_npc),
        .in_pred_pc(in_pred_pc), .in_branch_mask(in_branch_mask), .in_branch_stack(in_branch_stack),
        .enq_count(enq_count), .free_entries(free_entries), .occupancy(occupancy),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_npc(out_npc),
        .out_pred_pc(out_pred_pc), .out_branch_mask(out_branch_mask),
        .out_branch_stack(out_branch_stack), .deq_count(deq_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t        mq[$];
    int          e_enq, e_deq;
    logic [2:0]  e_valid;
    logic [95:0] e_inst, e_pc, e_npc, e_pred;
    logic [11:0] e_mask, e_stack;

    function automatic void compute_expect();
        int   n, pre, cnt;
        logic misp, ok, alive, v;
        ent_t e;
        n    = mq.size();
        misp = br_resolve_valid && !br_correct;
        ok   = br_resolve_valid && br_correct;
        pre  = 0;
        for (int j = 0; j < 4; j++) begin
            if (!in_valid[j]) break;
            pre++;
        end
        e_enq = (!reset_n || flush || misp) ? 0 : ((pre < 8 - n) ? pre : 8 - n);
        e_valid = '0; e_inst = '0; e_pc = '0; e_npc = '0; e_pred = '0; e_mask = '0; e_stack = '0;
        alive = 1'b1;
        cnt   = 0;
        e     = '0;
        for (int k = 0; k < 3; k++) begin
            v = alive && (k < n) && !flush;
            if (v) begin
                e = mq[k];
                if (misp && ((e.mask & br_tag) != 0)) v = 1'b0;
                if (k > 0 && e.stack != 0) v = 1'b0;
            end
            e_valid[k] = v;
            if (v) begin
                e_inst[k*32 +: 32] = e.inst;
                e_pc[k*32 +: 32]   = e.pc;
                e_npc[k*32 +: 32]  = e.npc;
                e_pred[k*32 +: 32] = e.pred;
                e_mask[k*4 +: 4]   = e.mask & ~(ok ? br_tag : 4'b0);
                e_stack[k*4 +: 4]  = e.stack;
                cnt++;
                alive = (e.stack == 0);
            end else begin
                alive = 1'b0;
            end
        end
        e_deq = (int'(deq_count) < cnt) ? int'(deq_count) : cnt;
    endfunction

    function automatic void model_step();
        int   idx;
        logic misp, ok;
        ent_t e;
        compute_expect();
        misp = br_resolve_valid && !br_correct;
        ok   = br_resolve_valid && br_correct;
        if (flush) begin
            mq.delete();
        end else if (misp) begin
            idx = -1;
            for (int i = 0; i < mq.size(); i++)
                if (idx < 0 && ((mq[i].mask & br_tag) != 0)) idx = i;
            if (idx >= 0) while (mq.size() > idx) void'(mq.pop_back());
            repeat (e_deq) void'(mq.pop_front());
        end else begin
            if (ok) foreach (mq[i]) mq[i].mask = mq[i].mask & ~br_tag;
            repeat (e_deq) void'(mq.pop_front());
            for (int j = 0; j < e_enq; j++) begin
                e.inst  = in_inst[j*32 +: 32];
                e.pc    = in_pc[j*32 +: 32];
                e.npc   = in_npc[j*32 +: 32];
                e.pred  = in_pred_pc[j*32 +: 32];
                e.mask  = in_branch_mask[j*4 +: 4] & ~(ok ? br_tag : 4'b0);
                e.stack = in_branch_stack[j*4 +: 4];
                mq.push_back(e);
            end
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) mq.delete();
        else          model_step();
    end

    // Compare every cycle on the falling edge.
    always @(negedge clock) begin
        compute_expect();
        chk("m_enq",   enq_count, e_enq);
        chk("m_occ",   occupancy, mq.size());
        chk("m_free",  free_entries, 8 - mq.size());
        chk("m_valid", out_valid, e_valid);
        chk("m_inst",  out_inst, e_inst);
        chk("m_pc",    out_pc, e_pc);
        chk("m_npc",   out_npc, e_npc);
        chk("m_pred",  out_pred_pc, e_pred);
        chk("m_mask",  out_branch_mask, e_mask);
        chk("m_stack", out_branch_stack, e_stack);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        in_valid = '0; in_inst = '0; in_pc = '0; in_npc = '0; in_pred_pc = '0;
        in_branch_mask = '0; in_branch_stack = '0;
    endtask

    task automatic set_lane(input int j, input logic [31:0] pc, input logic [3:0] mask, input logic [3:0] stk);
        in_valid[j]               = 1'b1;
        in_inst[j*32 +: 32]       = pc ^ 32'hDEAD_0013;
        in_pc[j*32 +: 32]         = pc;
        in_npc[j*32 +: 32]        = pc + 32'd4;
        in_pred_pc[j*32 +: 32]    = (stk != 0) ? pc + 32'h40 : pc + 32'd4;
        in_branch_mask[j*4 +: 4]  = mask;
        in_branch_stack[j*4 +: 4] = stk;
    endtask

    task automatic do_flush();
        clr_in();
        deq_count = 0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; br_resolve_valid = 1'b0; br_correct = 1'b0;
        br_tag = '0; deq_count = '0;
        clr_in();
        tick();
        chk("rst_occ",   occupancy, 0);
        chk("rst_free",  free_entries, 8);
        chk("rst_valid", out_valid, 0);
        chk("rst_enq",   enq_count, 0);
        reset_n = 1'b1;

        // Four lanes into an empty queue.
        for (int j = 0; j < 4; j++) set_lane(j, 32'(4 * j), 4'b0, 4'b0);
        #1 chk("s1_enq", enq_count, 4);
        tick();
        clr_in();
        #1;
        chk("s1_occ",   occupancy, 4);
        chk("s1_valid", out_valid, 3'b111);
        chk("s1_pc0",   out_pc[31:0], 32'h00);
        chk("s1_pc1",   out_pc[63:32], 32'h04);
        chk("s1_pc2",   out_pc[95:64], 32'h08);

        // Fill to 7, then overflow attempt, then full with dequeue.
        for (int j = 0; j < 3; j++) set_lane(j, 32'h10 + 32'(4 * j), 4'b0, 4'b0);
        tick();
        clr_in();
        for (int j = 0; j < 4; j++) set_lane(j, 32'h1C + 32'(4 * j), 4'b0, 4'b0);
        #1 chk("s2_enq_clamp", enq_count, 1);
        tick();
        #1;
        chk("s2_occ_full", occupancy, 8);
        chk("s2_free0",    free_entries, 0);
        deq_count = 3;
        #1 chk("s2_enq_full", enq_count, 0);
        tick();
        deq_count = 0;
        clr_in();
        #1;
        chk("s2_occ5", occupancy, 5);
        chk("s2_head", out_pc[31:0], 32'h0C);

        // Branch placement rules.
        do_flush();
        #1 chk("s3_flush_occ", occupancy, 0);
        set_lane(0, 32'h100, 4'b0000, 4'b0000);
        set_lane(1, 32'h104, 4'b0000, 4'b0010);
        set_lane(2, 32'h108, 4'b0010, 4'b0000);
        set_lane(3, 32'h10C, 4'b0010, 4'b0000);
        tick();
        clr_in();
        #1 chk("s3_valid_a", out_valid, 3'b001);
        deq_count = 1;
        tick();
        deq_count = 0;
        #1;
        chk("s3_valid_b", out_valid, 3'b001);
        chk("s3_br_pc",   out_pc[31:0], 32'h104);

        // Mispredict squash.
        do_flush();
        set_lane(0, 32'h200, 4'b0000, 4'b0);
        set_lane(1, 32'h204, 4'b0000, 4'b0);
        set_lane(2, 32'h208, 4'b0010, 4'b0);
        set_lane(3, 32'h20C, 4'b0010, 4'b0);
        tick();
        clr_in();
        set_lane(0, 32'h210, 4'b0010, 4'b0);
        set_lane(1, 32'h214, 4'b0010, 4'b0);
        tick();
        clr_in();
        #1 chk("s4_occ6", occupancy, 6);
        br_resolve_valid = 1'b1; br_correct = 1'b0; br_tag = 4'b0010;
        set_lane(0, 32'h300, 4'b0000, 4'b0);
        #1;
        chk("s4_enq_blk", enq_count, 0);
        chk("s4_valid_same", out_valid, 3'b011);
        tick();
        br_resolve_valid = 1'b0;
        clr_in();
        #1;
        chk("s4_occ2",   occupancy, 2);
        chk("s4_free6",  free_entries, 6);
        chk("s4_valid",  out_valid, 3'b011);
        set_lane(0, 32'h218, 4'b0000, 4'b0);
        tick();
        clr_in();
        #1;
        chk("s4_tail_pc", out_pc[95:64], 32'h218);
        chk("s4_occ3",    occupancy, 3);

        // Correct resolve clears mask bits.
        do_flush();
        for (int j = 0; j < 3; j++) set_lane(j, 32'h400 + 32'(4 * j), 4'b0011, 4'b0);
        tick();
        clr_in();
        br_resolve_valid = 1'b1; br_correct = 1'b1; br_tag = 4'b0010;
        #1;
        chk("s5_mask_comb", out_branch_mask[3:0], 4'b0001);
        chk("s5_occ",       occupancy, 3);
        tick();
        br_resolve_valid = 1'b0; br_correct = 1'b0; br_tag = '0;
        #1;
        chk("s5_mask_store", out_branch_mask, 12'h111);
        chk("s5_occ_after",  occupancy, 3);

        // Steady 3-in/3-out streaming across pointer wrap.
        do_flush();
        for (int i = 0; i < 20; i++) begin
            clr_in();
            for (int j = 0; j < 3; j++) set_lane(j, 32'h1000 + 32'(12 * i + 4 * j), 4'b0, 4'b0);
            deq_count = 3;
            #1;
            if (i > 0) begin
                chk("s6_pc0", out_pc[31:0],  32'h1000 + 32'(12 * (i - 1)));
                chk("s6_pc2", out_pc[95:64], 32'h1008 + 32'(12 * (i - 1)));
            end
            tick();
        end
        #1 chk("s6_occ", occupancy, 3);

        // Asynchronous reset in the middle of a cycle.
        #1 reset_n = 1'b0;
        #1;
        chk("ar_occ",   occupancy, 0);
        chk("ar_free",  free_entries, 8);
        chk("ar_valid", out_valid, 0);
        chk("ar_enq",   enq_count, 0);
        chk("ar_pc",    out_pc, 0);
        #3 reset_n = 1'b1;
        clr_in();
        deq_count = 0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
